// File: rtl/ecc_pkg.sv
// Shared definitions for the GF(2^163) ECC result path: field width, header tag
// constant and the unloader state encoding.
package ecc_pkg;

    localparam int unsigned M       = 163;
    localparam logic [15:0] ECC_TAG = 16'hEC0C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        SEND_X = 2'd2,
        SEND_Y = 2'd3
    } state_t;

endpackage

// File: rtl/ecc_result_unloader.sv
// ecc_result_unloader: captures a finished point Q=(xq,yq) from the scalar-multiply
// core on the done strobe and streams it out as W-bit words over valid/ready,
// x first then y, least-significant word first. One result in flight; a done
// arriving while busy is dropped and flagged on the sticky overrun output.
// Build option: define ECC_UNLOAD_TAG_EN to prefix each result with a header word
// {16'hEC0C, 8'h00, seq}, where seq counts captured results.
module ecc_result_unloader
    import ecc_pkg::*;
#(
    parameter int unsigned M = ecc_pkg::M,
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done,
    input  logic [M-1:0] xq,
    input  logic [M-1:0] yq,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         overrun
);

    localparam int unsigned NW  = (M + W - 1) / W;
    localparam int unsigned TOT = 2 * NW;
    localparam int unsigned IW  = $clog2(TOT);

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_idx;
    logic [2*NW*W-1:0]   r_cap;
    logic [7:0]          r_seq;
    logic                r_overrun;
    logic [NW*W-1:0]     w_x_ext;
    logic [NW*W-1:0]     w_y_ext;
    logic                w_capture;
    logic                w_fire;
    logic                w_x_end;
    logic                w_y_end;
    logic [W-1:0]        w_hdr;

`ifdef ECC_UNLOAD_TAG_EN
    logic [7:0]          r_hdr_seq;
`endif

    assign w_capture = (r_state == IDLE) && done;
    assign w_fire    = out_valid && out_ready;
    assign w_x_end   = (r_state == SEND_X) && (r_idx == IW'(NW - 1));
    assign w_y_end   = (r_state == SEND_Y) && (r_idx == IW'(TOT - 1));
    assign overrun   = r_overrun;

    // Zero-extend both coordinates to a whole number of output words.
    always_comb begin
        w_x_ext          = '0;
        w_y_ext          = '0;
        w_x_ext[M-1:0]   = xq;
        w_y_ext[M-1:0]   = yq;
    end

    // Header word for the tagged build; upper bits stay zero when W exceeds 32.
    always_comb begin
        w_hdr = '0;
`ifdef ECC_UNLOAD_TAG_EN
        w_hdr[31:0] = {ECC_TAG, 8'h00, r_hdr_seq};
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; outputs depend on state only, so they drop
    // to zero as soon as reset forces IDLE.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        case (r_state)
            IDLE: begin
                if (done) begin
`ifdef ECC_UNLOAD_TAG_EN
                    w_next = HDR;
`else
                    w_next = SEND_X;
`endif
                end
            end
            HDR: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = w_hdr;
                if (w_fire) w_next = SEND_X;
            end
            SEND_X: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = r_cap[r_idx*W +: W];
                if (w_fire && w_x_end) w_next = SEND_Y;
            end
            SEND_Y: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = w_y_end;
                out_data  = r_cap[r_idx*W +: W];
                if (w_fire && w_y_end) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Word index runs across x then y as one range, so a single part-select on the
    // packed {y,x} register serves both coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= '0;
        end else if (w_fire && (r_state == SEND_X || r_state == SEND_Y)) begin
            r_idx <= w_y_end ? '0 : r_idx + IW'(1);
        end
    end

    // Capture registers, result sequence counter and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap     <= '0;
            r_seq     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cap <= {w_y_ext, w_x_ext};
                r_seq <= r_seq + 8'd1;
            end
            if (done && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef ECC_UNLOAD_TAG_EN
    // Header carries the sequence number as it stood before this capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_seq <= '0;
        end else if (w_capture) begin
            r_hdr_seq <= r_seq;
        end
    end
`endif

endmodule

// File: tb/tb_ecc_result_unloader.sv
// Self-checking bench for ecc_result_unloader (default build, 12 words per result).
// Table-driven stream vectors plus hand-written overrun and mid-stream reset sequences.
module tb_ecc_result_unloader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         done = 1'b0;
    logic [162:0] xq = '0;
    logic [162:0] yq = '0;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         busy;
    logic         overrun;

    int n_chk  = 0;
    int n_pass = 0;

    ecc_result_unloader #(.M(163), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .xq        (xq),
        .yq        (yq),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [162:0] x;
        logic [162:0] y;
        logic [15:0]  rmask;
        logic [383:0] exp;   // word k at [k*32 +: 32]; x words 0..5, y words 6..11
    } vec_t;

    vec_t vecs[3];

    logic [162:0] junk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
        else n_pass++;
    endtask

    // Called at a negedge with the unloader idle. Pulses done this cycle, then receives
    // 12 words. done_at/rst_at inject a second done or a reset while word k is presented.
    task automatic run_stream(input string nm, input logic [162:0] x, input logic [162:0] y,
                              input logic [383:0] exp, input logic [15:0] rmask,
                              input int done_at, input int rst_at);
        int k = 0;
        int cyc = 0;
        int ph = 0;
        logic stalled = 1'b0;
        logic [31:0] held = '0;
        logic injected = 1'b0;
        xq = x;
        yq = y;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        xq = junk;
        yq = junk;
        chk({nm, " latency valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, " busy"}, {31'd0, busy}, 32'd1);
        while (k < 12 && cyc < 200) begin
            if (stalled) chk({nm, " hold"}, out_data, held);
            out_ready = rmask[ph % 16];
            ph++;
            if (rst_at == k) begin
                #2 rst = 1'b1;
                #1;
                chk({nm, " rst valid"}, {31'd0, out_valid}, 32'd0);
                chk({nm, " rst data"}, out_data, 32'd0);
                chk({nm, " rst busy"}, {30'd0, busy, overrun}, 32'd0);
                out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (done_at == k && !injected) begin
                done = 1'b1;
                injected = 1'b1;
            end else begin
                done = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk($sformatf("%s word%0d", nm, k), out_data, exp[k*32 +: 32]);
                chk($sformatf("%s last%0d", nm, k), {31'd0, out_last}, (k == 11) ? 32'd1 : 32'd0);
                k++;
                stalled = 1'b0;
            end else if (out_valid) begin
                held = out_data;
                stalled = 1'b1;
            end else begin
                chk($sformatf("%s bubble%0d", nm, k), {31'd0, out_valid}, 32'd1);
            end
            @(negedge clk);
            cyc++;
        end
        done = 1'b0;
        out_ready = 1'b0;
        chk({nm, " word count"}, k, 32'd12);
        chk({nm, " end idle"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        junk = 163'h3_1234ABCD_5678EF01_13579BDF_2468ACE0_FEDCBA98;

        vecs[0].name  = "basic";
        vecs[0].x     = 163'h4;
        vecs[0].y     = 163'h5;
        vecs[0].rmask = 16'hFFFF;
        vecs[0].exp   = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5,
                         32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4};

        vecs[1].name  = "ones_bp";
        vecs[1].x     = {163{1'b1}};
        vecs[1].y     = {163{1'b1}};
        vecs[1].rmask = 16'h5555;
        vecs[1].exp   = {32'h7, {5{32'hFFFFFFFF}}, 32'h7, {5{32'hFFFFFFFF}}};

        vecs[2].name  = "pattern";
        vecs[2].x     = 163'h5_44444444_33333333_22222222_11111111_DEADBEEF;
        vecs[2].y     = 163'h2_0BADF00D_CAFEBABE_12345678_9ABCDEF0_0F0F0F0F;
        vecs[2].rmask = 16'hC3A7;
        vecs[2].exp   = {32'h2, 32'h0BADF00D, 32'hCAFEBABE, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
                         32'h5, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};

        // Reset: outputs stay 0 while rst held, even with done pulsed.
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            done = (i == 1);
            #1;
            chk($sformatf("reset out%0d", i), {out_data[3:0], out_valid, out_last, busy, overrun}, 32'd0);
        end
        done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post reset idle", {28'd0, out_valid, out_last, busy, overrun}, 32'd0);

        // Table-driven streams, each started in the first idle cycle after the previous one.
        for (int unsigned v = 0; v < 3; v++) begin
            run_stream(vecs[v].name, vecs[v].x, vecs[v].y, vecs[v].exp, vecs[v].rmask, -1, -1);
        end
        chk("no overrun yet", {31'd0, overrun}, 32'd0);

        // Overrun: done at word 3 is dropped; original stream continues.
        run_stream("ovr", vecs[0].x, vecs[0].y, vecs[0].exp, 16'hFFFF, 3, -1);
        chk("overrun set", {31'd0, overrun}, 32'd1);
        // done in the first idle cycle after finishing is captured.
        run_stream("after_ovr", vecs[2].x, vecs[2].y, vecs[2].exp, 16'hFFFF, -1, -1);
        chk("overrun sticky", {31'd0, overrun}, 32'd1);

        // Mid-stream reset at word 7, then a clean stream from word 0.
        run_stream("midrst", vecs[2].x, vecs[2].y, vecs[2].exp, 16'hFFFF, -1, 7);
        chk("overrun cleared", {31'd0, overrun}, 32'd0);
        run_stream("after_rst", vecs[0].x, vecs[0].y, vecs[0].exp, 16'h3333, -1, -1);
        chk("clean no overrun", {31'd0, overrun}, 32'd0);

        // done coinciding with acceptance of the last word is dropped.
        run_stream("lastedge", vecs[1].x, vecs[1].y, vecs[1].exp, 16'hFFFF, 11, -1);
        chk("lastedge overrun", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        chk("lastedge dropped", {30'd0, out_valid, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
